// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU and unified memory
// over several cycles per instruction, stalling on the memory ready handshake.
// All outputs are Moore-style decodes of the current state, with a few
// qualified by op/funct/Zero/MemReady as the datapath needs.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] alu_op_s;

    // ALU operation from the internal ALUOp class and the instruction funct fields.
    function automatic logic [2:0] alu_decode(input logic [1:0] alu_op,
                                              input logic [2:0] f3,
                                              input logic       op5,
                                              input logic       f7b5);
        logic [2:0] ctrl;
        case (alu_op)
            2'b00: ctrl = 3'b000;
            2'b01: ctrl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  ctrl = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  ctrl = 3'b101;
                    3'b100:  ctrl = 3'b100;
                    3'b110:  ctrl = 3'b011;
                    3'b111:  ctrl = 3'b010;
                    default: ctrl = 3'b000;
                endcase
            end
            default: ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

    // State register; reset aborts any instruction and returns to FETCH at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        next_state_s = FETCH;
        alu_op_s     = 2'b00;
        MemReq       = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        IllegalInstr = 1'b0;
        case (state_r)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                // Computes the branch/jump target into ALUOut ahead of need.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = EXECR;
                    OP_ITYPE:     next_state_s = EXECI;
                    OP_BR:        next_state_s = BRANCH;
                    OP_JAL:       next_state_s = JAL;
                    default: begin
                        next_state_s = FETCH;
                        IllegalInstr = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op[5]) begin
                    next_state_s = MEMWRITE;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMWB: begin
                ResultSrc    = 2'b01;
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            EXECR: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b00;
                alu_op_s     = 2'b10;
                next_state_s = ALUWB;
            end
            EXECI: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                alu_op_s     = 2'b10;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                // PC takes the target from DECODE; ALUWB then writes PC+4 as the link.
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                PCWrite      = 1'b1;
                next_state_s = ALUWB;
            end
            BRANCH: begin
                ALUSrcA      = 2'b10;
                alu_op_s     = 2'b01;
                PCWrite      = Zero ^ funct3[0];
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            default: ImmSrc = 3'b000;
        endcase
    end

    assign ALUControl = alu_decode(alu_op_s, funct3, op[5], funct7b5);
    assign State      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control words are
// queued as stimulus is applied and popped for comparison at the falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, adr, mw, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, aluc;
        logic       ill;
    } outs_t;

    outs_t exp_q[$];
    string tag_q[$];
    logic [6:0] cur_op;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic outs_t base(input logic [3:0] st);
        outs_t o;
        o = '0;
        o.st = st;
        o.imm = imm_of(cur_op);
        return o;
    endfunction

    function automatic outs_t e_fetch(input logic mr);
        outs_t o = base(4'd0);
        o.mreq = 1'b1; o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr;
        return o;
    endfunction
    function automatic outs_t e_decode(input logic ill);
        outs_t o = base(4'd1);
        o.sa = 2'b01; o.sb = 2'b01; o.ill = ill;
        return o;
    endfunction
    function automatic outs_t e_memadr();
        outs_t o = base(4'd2);
        o.sa = 2'b10; o.sb = 2'b01;
        return o;
    endfunction
    function automatic outs_t e_memread();
        outs_t o = base(4'd3);
        o.mreq = 1'b1; o.adr = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_memwb();
        outs_t o = base(4'd4);
        o.rs = 2'b01; o.rw = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_memwrite();
        outs_t o = base(4'd5);
        o.mreq = 1'b1; o.adr = 1'b1; o.mw = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_exec(input logic [3:0] st, input logic [1:0] sb,
                                     input logic [2:0] aluc);
        outs_t o = base(st);
        o.sa = 2'b10; o.sb = sb; o.aluc = aluc;
        return o;
    endfunction
    function automatic outs_t e_aluwb();
        outs_t o = base(4'd8);
        o.rw = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_jal();
        outs_t o = base(4'd9);
        o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
        return o;
    endfunction
    function automatic outs_t e_branch(input logic pcw);
        outs_t o = base(4'd10);
        o.sa = 2'b10; o.aluc = 3'b001; o.pcw = pcw;
        return o;
    endfunction

    // Queue the expectation for this cycle, compare at the falling edge, advance.
    task automatic cyc(input outs_t e, input string tag);
        outs_t obs, ex;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {State, MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr};
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, ex);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; cur_op = o; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        @(posedge clk); #1;

        // Reset and release with memory not ready, then a ready fetch.
        cyc(e_fetch(1'b0), "rst_hold");
        reset = 1'b0;
        cyc(e_fetch(1'b0), "rst_release");
        MemReady = 1'b1;
        cyc(e_fetch(1'b1), "fetch_ready");

        // lw with zero-wait memory: 1,2,3,4 then FETCH.
        cyc(e_decode(1'b0), "lw_decode");
        cyc(e_memadr(), "lw_memadr");
        cyc(e_memread(), "lw_memread");
        cyc(e_memwb(), "lw_memwb");

        // sw with three wait cycles in MEMWRITE.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(e_fetch(1'b1), "sw_fetch");
        cyc(e_decode(1'b0), "sw_decode");
        cyc(e_memadr(), "sw_memadr");
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc(e_memwrite(), "sw_memwrite_wait");
        MemReady = 1'b1;
        cyc(e_memwrite(), "sw_memwrite_done");

        // R-type sub.
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc(e_fetch(1'b1), "sub_fetch");
        cyc(e_decode(1'b0), "sub_decode");
        cyc(e_exec(4'd6, 2'b00, 3'b001), "sub_execr");
        cyc(e_aluwb(), "sub_aluwb");

        // addi with the same funct bits must add.
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc(e_fetch(1'b1), "addi_fetch");
        cyc(e_decode(1'b0), "addi_decode");
        cyc(e_exec(4'd7, 2'b01, 3'b000), "addi_execi");
        cyc(e_aluwb(), "addi_aluwb");

        // and / slt / xor / or decodes in EXECR.
        set_instr(7'b0110011, 3'b111, 1'b0);
        cyc(e_fetch(1'b1), "and_fetch");
        cyc(e_decode(1'b0), "and_decode");
        cyc(e_exec(4'd6, 2'b00, 3'b010), "and_execr");
        cyc(e_aluwb(), "and_aluwb");
        set_instr(7'b0010011, 3'b010, 1'b0);
        cyc(e_fetch(1'b1), "slti_fetch");
        cyc(e_decode(1'b0), "slti_decode");
        cyc(e_exec(4'd7, 2'b01, 3'b101), "slti_execi");
        cyc(e_aluwb(), "slti_aluwb");
        set_instr(7'b0110011, 3'b100, 1'b0);
        cyc(e_fetch(1'b1), "xor_fetch");
        cyc(e_decode(1'b0), "xor_decode");
        cyc(e_exec(4'd6, 2'b00, 3'b100), "xor_execr");
        cyc(e_aluwb(), "xor_aluwb");
        set_instr(7'b0010011, 3'b110, 1'b1);
        cyc(e_fetch(1'b1), "ori_fetch");
        cyc(e_decode(1'b0), "ori_decode");
        cyc(e_exec(4'd7, 2'b01, 3'b011), "ori_execi");
        cyc(e_aluwb(), "ori_aluwb");

        // beq taken, bne not taken, bne taken.
        Zero = 1'b1;
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc(e_fetch(1'b1), "beq_fetch");
        cyc(e_decode(1'b0), "beq_decode");
        cyc(e_branch(1'b1), "beq_taken");
        set_instr(7'b1100011, 3'b001, 1'b0);
        cyc(e_fetch(1'b1), "bne_fetch");
        cyc(e_decode(1'b0), "bne_decode");
        cyc(e_branch(1'b0), "bne_zero1");
        Zero = 1'b0;
        cyc(e_fetch(1'b1), "bne2_fetch");
        cyc(e_decode(1'b0), "bne2_decode");
        cyc(e_branch(1'b1), "bne_zero0");

        // jal: 0,1,9,8,0.
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc(e_fetch(1'b1), "jal_fetch");
        cyc(e_decode(1'b0), "jal_decode");
        cyc(e_jal(), "jal_jal");
        cyc(e_aluwb(), "jal_aluwb");

        // Unsupported opcode.
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc(e_fetch(1'b1), "ill_fetch");
        cyc(e_decode(1'b1), "ill_decode");
        cyc(e_fetch(1'b1), "ill_back_fetch");

        // Reset while stalled in MEMREAD.
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc(e_decode(1'b0), "lw2_decode");
        cyc(e_memadr(), "lw2_memadr");
        MemReady = 1'b0;
        cyc(e_memread(), "lw2_memread");
        reset = 1'b1;
        #1;
        checks++;
        assert (State === 4'd0) else begin
            errors++;
            $error("FAIL async_reset observed %0d expected 0", State);
        end
        cyc(e_fetch(1'b0), "abort_reset");
        reset = 1'b0;
        MemReady = 1'b1;
        cyc(e_fetch(1'b1), "abort_fetch");
        cyc(e_decode(1'b0), "abort_decode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
